// File: rtl/algo_2r2w_pkg.sv
// Shared constants and helpers for the 2R2W read-response buffer.
package algo_2r2w_pkg;

  localparam int DEF_BITDEPTH = 2;
  localparam int CNTW = DEF_BITDEPTH + 1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/algo_2r2w_rsp_fifo.sv
// Per-port response FIFO: registered storage, push/pop bookkeeping and sticky overflow flag.
module algo_2r2w_rsp_fifo
  import algo_2r2w_pkg::*;
#(
  parameter int WIDTH    = 15,
  parameter int DEPTH    = 4,
  parameter int BITDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             guard,
  input  logic             inVld,
  input  logic [WIDTH-1:0] inDat,
  input  logic             outRdy,
  output logic             outVld,
  output logic [WIDTH-1:0] outDat,
  output logic             ovfErr
);

  localparam int PW = (BITDEPTH > 0) ? BITDEPTH : 1;
  localparam int CW = BITDEPTH + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptrReg;
  logic [PW-1:0]    rptrReg;
  logic [CW-1:0]    occReg;
  logic             ovfReg;

  logic full;
  logic pop;
  logic push;
  logic accept;
  logic drop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  assign full   = (occReg == CW'(DEPTH));
  assign outVld = (occReg != '0);
  assign outDat = mem[rptrReg];
  assign pop    = outVld & outRdy;
  assign push   = inVld & ~guard;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[wptrReg] <= inDat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptrReg <= '0;
      rptrReg <= '0;
      occReg  <= '0;
      ovfReg  <= 1'b0;
    end else begin
      if (accept) wptrReg <= nextPtr(wptrReg);
      if (pop)    rptrReg <= nextPtr(rptrReg);
      occReg <= occReg + CW'(accept) - CW'(pop);
      if (drop) ovfReg <= 1'b1;
    end
  end

  assign ovfErr = ovfReg;

endmodule

// File: rtl/algo_2r2w_rd_rsp_buf.sv
// Read-response buffer with per-port credit gating in front of a non-stalling 2R2W wrapper.
module algo_2r2w_rd_rsp_buf
  import algo_2r2w_pkg::*;
#(
  parameter int NUMRDPRT = 2,
  parameter int BITADDR  = 8,
  parameter int WIDTH    = 15,
  parameter int RD_LAT   = 1,
  parameter int DEPTH    = 4,
  parameter int BITDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUMRDPRT-1:0]          req_vld,
  input  logic [NUMRDPRT*BITADDR-1:0]  req_adr,
  output logic [NUMRDPRT-1:0]          req_rdy,
  output logic [NUMRDPRT-1:0]          mem_read,
  output logic [NUMRDPRT*BITADDR-1:0]  mem_rd_adr,
  input  logic [NUMRDPRT-1:0]          mem_rd_vld,
  input  logic [NUMRDPRT*WIDTH-1:0]    mem_rd_dout,
  output logic [NUMRDPRT-1:0]          rsp_vld,
  output logic [NUMRDPRT*WIDTH-1:0]    rsp_dout,
  input  logic [NUMRDPRT-1:0]          rsp_rdy,
  output logic [NUMRDPRT-1:0]          ovf_err
);

  localparam int CW = BITDEPTH + 1;

  logic guard;

  // Reads launched before reset may still return; the guard swallows them for RD_LAT cycles.
  generate
    if (RD_LAT > 0) begin : gen_guard
      localparam int GW = (clog2(RD_LAT + 1) > 0) ? clog2(RD_LAT + 1) : 1;
      logic [GW-1:0] guardReg;
      always_ff @(posedge clk) begin
        if (rst) begin
          guardReg <= GW'(RD_LAT);
        end else if (guardReg != '0) begin
          guardReg <= guardReg - GW'(1);
        end
      end
      assign guard = (guardReg != '0);
    end else begin : gen_noguard
      assign guard = 1'b0;
    end
  endgenerate

  assign mem_rd_adr = req_adr;

  genvar gi;
  generate
    for (gi = 0; gi < NUMRDPRT; gi++) begin : gen_port
      logic [CW-1:0] cntReg;
      logic          rdy;
      logic          issue;
      logic          pop;
      logic          fifoVld;
      logic          fifoOvf;

      // Credit covers both in-flight reads and stored responses.
      assign rdy   = ~rst & ~guard & (cntReg < CW'(DEPTH));
      assign issue = req_vld[gi] & rdy;
      assign pop   = rsp_vld[gi] & rsp_rdy[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          cntReg <= '0;
        end else begin
          cntReg <= cntReg + CW'(issue) - CW'(pop);
        end
      end

      assign req_rdy[gi]  = rdy;
      assign mem_read[gi] = issue;
      assign rsp_vld[gi]  = fifoVld & ~rst;
      assign ovf_err[gi]  = fifoOvf & ~rst;

      algo_2r2w_rsp_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .BITDEPTH(BITDEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .guard (guard),
        .inVld (mem_rd_vld[gi]),
        .inDat (mem_rd_dout[gi*WIDTH +: WIDTH]),
        .outRdy(rsp_rdy[gi] & ~rst),
        .outVld(fifoVld),
        .outDat(rsp_dout[gi*WIDTH +: WIDTH]),
        .ovfErr(fifoOvf)
      );
    end
  endgenerate

endmodule

// File: tb/tb_algo_2r2w_rd_rsp_buf.sv
// Randomized scoreboard bench for algo_2r2w_rd_rsp_buf with a behavioural wrapper and credit model.
module tb_algo_2r2w_rd_rsp_buf;

  localparam int NP = 2;
  localparam int BA = 8;
  localparam int W  = 15;
  localparam int RL = 3;
  localparam int D  = 4;
  localparam int BD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NP-1:0]       req_vld, req_rdy, mem_read, mem_rd_vld, rsp_vld, rsp_rdy, ovf_err;
  logic [NP*BA-1:0]    req_adr, mem_rd_adr;
  logic [NP*W-1:0]     mem_rd_dout, rsp_dout;
  logic [NP-1:0]       wrapVld, inj;
  logic [NP*W-1:0]     wrapDat;

  algo_2r2w_rd_rsp_buf #(
    .NUMRDPRT(NP), .BITADDR(BA), .WIDTH(W), .RD_LAT(RL), .DEPTH(D), .BITDEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_adr(req_adr), .req_rdy(req_rdy),
    .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
    .mem_rd_vld(mem_rd_vld), .mem_rd_dout(mem_rd_dout),
    .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .rsp_rdy(rsp_rdy),
    .ovf_err(ovf_err)
  );

  assign mem_rd_vld = wrapVld | inj;
  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : gen_dout
      assign mem_rd_dout[gi*W +: W] = inj[gi] ? 15'h5555 : wrapDat[gi*W +: W];
    end
  endgenerate

  typedef struct {
    logic [W-1:0] dat;
    int           rdyCyc;
  } exp_t;

  exp_t          expQ [NP][$];
  logic [W-1:0]  memArr [256];
  bit            retVld [NP][16];
  logic [W-1:0]  retDat [NP][16];
  int            cyc = 0;
  int            passCnt = 0;
  int            totCnt = 0;
  int            acceptCnt [NP];
  int            guardLeft = RL;
  bit            expOvf [NP];

  task automatic chk(input string name, input longint act, input longint req);
    totCnt++;
    if (act == req) passCnt++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
  endtask

  // Wrapper model: returns memArr[adr] exactly RL cycles after each mem_read.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int p = 0; p < NP; p++) begin
      wrapVld[p]          = retVld[p][cyc % 16];
      wrapDat[p*W +: W]   = retDat[p][cyc % 16];
      retVld[p][cyc % 16] = 1'b0;
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (mem_read[p]) begin
        retVld[p][(cyc + RL) % 16] = 1'b1;
        retDat[p][(cyc + RL) % 16] = memArr[mem_rd_adr[p*BA +: BA]];
      end
      if (rst) begin
        chk($sformatf("rst_req_rdy%0d", p), req_rdy[p], 0);
        chk($sformatf("rst_rsp_vld%0d", p), rsp_vld[p], 0);
        chk($sformatf("rst_mem_read%0d", p), mem_read[p], 0);
        chk($sformatf("rst_ovf%0d", p), ovf_err[p], 0);
        expQ[p].delete();
        expOvf[p] = 1'b0;
      end else begin
        bit expRdy, expVld, popNow;
        int storedN;
        expRdy = (guardLeft == 0) && (expQ[p].size() < D);
        expVld = (expQ[p].size() > 0) && (expQ[p][0].rdyCyc <= cyc);
        chk($sformatf("req_rdy%0d", p), req_rdy[p], expRdy);
        chk($sformatf("rsp_vld%0d", p), rsp_vld[p], expVld);
        chk($sformatf("mem_read%0d", p), mem_read[p], req_vld[p] & expRdy);
        chk($sformatf("mem_rd_adr%0d", p), mem_rd_adr[p*BA +: BA], req_adr[p*BA +: BA]);
        chk($sformatf("ovf_err%0d", p), ovf_err[p], expOvf[p]);
        storedN = 0;
        foreach (expQ[p][i]) if (expQ[p][i].rdyCyc <= cyc) storedN++;
        popNow = expVld & rsp_rdy[p];
        if (popNow) begin
          chk($sformatf("rsp_dout%0d", p), rsp_dout[p*W +: W], expQ[p][0].dat);
          void'(expQ[p].pop_front());
        end
        if (inj[p] && storedN == D && !popNow) expOvf[p] = 1'b1;
        if (req_vld[p] && expRdy) begin
          exp_t e;
          e.dat    = memArr[req_adr[p*BA +: BA]];
          e.rdyCyc = cyc + RL + 1;
          expQ[p].push_back(e);
          acceptCnt[p]++;
        end
      end
    end
    if (rst) guardLeft = RL;
    else if (guardLeft > 0) guardLeft--;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randAdr();
    for (int p = 0; p < NP; p++) req_adr[p*BA +: BA] = BA'($urandom_range(0, 255));
  endtask

  initial begin
    int n, b0, b1;
    rst = 1'b1; req_vld = '0; rsp_rdy = '0; req_adr = '0; inj = '0;
    wrapVld = '0; wrapDat = '0;
    for (int p = 0; p < NP; p++) begin
      acceptCnt[p] = 0;
      expOvf[p] = 1'b0;
      for (int s = 0; s < 16; s++) begin
        retVld[p][s] = 1'b0;
        retDat[p][s] = '0;
      end
    end
    for (int a = 0; a < 256; a++) memArr[a] = W'($urandom);
    memArr[8'h12] = 15'h1ABC;

    // Reset held 3 cycles, then guard window.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step();

    // Single read on port 0.
    rsp_rdy = 2'b11;
    req_adr[0 +: BA] = 8'h12;
    req_vld[0] = 1'b1;
    b0 = acceptCnt[0]; n = 0;
    do begin step(); n++; end while (acceptCnt[0] == b0 && n < 20);
    req_vld[0] = 1'b0;
    chk("single_accept", acceptCnt[0] - b0, 1);
    repeat (RL + 3) step();

    // Backpressure: exactly DEPTH accepts while nothing pops.
    rsp_rdy[0] = 1'b0;
    b0 = acceptCnt[0];
    req_vld[0] = 1'b1;
    repeat (10) begin randAdr(); step(); end
    chk("bp_accepts", acceptCnt[0] - b0, D);
    rsp_rdy[0] = 1'b1;
    repeat (10) begin randAdr(); step(); end
    req_vld = '0;
    repeat (8) step();

    // Sustained traffic: 100 reads per port.
    b0 = acceptCnt[0]; b1 = acceptCnt[1]; n = 0;
    req_vld = 2'b11;
    while ((acceptCnt[0] - b0 < 100 || acceptCnt[1] - b1 < 100) && n < 600) begin
      if (acceptCnt[0] - b0 >= 100) req_vld[0] = 1'b0;
      if (acceptCnt[1] - b1 >= 100) req_vld[1] = 1'b0;
      randAdr(); step(); n++;
    end
    req_vld = '0;
    chk("full_rate_acc0", acceptCnt[0] - b0, 100);
    chk("full_rate_acc1", acceptCnt[1] - b1, 100);
    repeat (10) step();

    // Random traffic with random backpressure.
    repeat (300) begin
      req_vld = NP'($urandom); rsp_rdy = NP'($urandom); randAdr(); step();
    end
    req_vld = '0; rsp_rdy = 2'b11;
    repeat (12) step();
    chk("drain_q0", expQ[0].size(), 0);
    chk("drain_q1", expQ[1].size(), 0);

    // Reset with two reads in flight per port.
    req_vld = 2'b11;
    repeat (2) begin randAdr(); step(); end
    req_vld = '0;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (10) step();
    chk("midrst_q0", expQ[0].size(), 0);

    // Forced overflow on port 0.
    rsp_rdy[0] = 1'b0;
    req_vld[0] = 1'b1;
    b0 = acceptCnt[0]; n = 0;
    while (acceptCnt[0] - b0 < D && n < 20) begin randAdr(); step(); n++; end
    req_vld = '0;
    chk("ovf_fill", acceptCnt[0] - b0, D);
    repeat (RL + 3) step();
    inj[0] = 1'b1; step(); inj[0] = 1'b0;
    repeat (3) step();
    chk("ovf_set", expOvf[0], 1);
    rsp_rdy[0] = 1'b1;
    repeat (8) step();
    chk("ovf_drain", expQ[0].size(), 0);
    rst = 1'b1; step(); rst = 1'b0;
    repeat (6) step();

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
